relm_custom_div_seq: RTL

- Parametrised multi-cycle divider for the ReLM custom-op path.
- Replaces the software-driven DIV/DIVLOOP and FDIV/FDIVLOOP sequences, which retire 2 quotient bits per instruction, with a self-timed engine retiring BPC bits per clock.
- Supports unsigned integer, signed integer and FP-mantissa division with sticky bit.
- Sits beside relm_custom: the core issues start, stalls on busy_out, and collects the result on valid_out.

---
 rtl/relm_div_pkg.sv | 34 +++
 rtl/relm_div_step.sv | 36 +++
 rtl/relm_custom_div_seq.sv | 194 +++++++++++++++++++
 3 files changed

// File: rtl/relm_div_pkg.sv
// relm_div_pkg
// Shared definitions for the ReLM sequential divider:
//   - mode encodings presented on mode_in
//   - divider FSM state encoding
//   - default geometry (ITER, CNT_W) plus helper functions so a parameterised
//     instance can derive its own iteration count and counter width.
package relm_div_pkg;

  localparam logic [1:0] DIVM_U  = 2'b00;
  localparam logic [1:0] DIVM_S  = 2'b01;
  localparam logic [1:0] DIVM_FP = 2'b10;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_LOOP = 2'b01,
    S_POST = 2'b10
  } divState_e;

  localparam int DEF_WD  = 32;
  localparam int DEF_BPC = 2;
  localparam int ITER    = DEF_WD / DEF_BPC;
  localparam int CNT_W   = $clog2(ITER + 1);

  // Number of LOOP cycles for a given width / bits-per-clock pair.
  function automatic int divIter(input int wd, input int bpc);
    return wd / bpc;
  endfunction

  // Counter width able to hold the iteration count itself.
  function automatic int divCntW(input int wd, input int bpc);
    return $clog2((wd / bpc) + 1);
  endfunction

endpackage

// File: rtl/relm_div_step.sv
// relm_div_step
// One combinational restoring-division step.
// Ports:
//   rem_i  [WD:0]   partial remainder entering the step
//   d_i    [WD-1:0] divisor magnitude
//   bit_i           bit shifted into the remainder LSB
//   rem_o  [WD:0]   partial remainder leaving the step
//   q_o             quotient bit produced by this step
module relm_div_step
  import relm_div_pkg::*;
#(
  parameter int WD = DEF_WD
) (
  input  logic [WD:0]   rem_i,
  input  logic [WD-1:0] d_i,
  input  logic          bit_i,
  output logic [WD:0]   rem_o,
  output logic          q_o
);

  logic [WD:0] shifted;
  logic [WD:0] dExt;
  logic        geq;

  // Shift first, then trial-subtract. A set rem_i MSB means the shifted value
  // would exceed WD+1 bits and is therefore certainly >= d; the subtraction
  // result is still correct modulo 2^(WD+1).
  always_comb begin
    shifted = {rem_i[WD-1:0], bit_i};
    dExt    = {1'b0, d_i};
    geq     = rem_i[WD] | (shifted >= dExt);
    q_o     = geq;
    rem_o   = geq ? (shifted - dExt) : shifted;
  end

endmodule

// File: rtl/relm_custom_div_seq.sv
// relm_custom_div_seq
// Self-timed multi-cycle restoring divider for the ReLM custom-op path,
// retiring BPC quotient bits per clock.
// Ports:
//   clk, reset            clock, synchronous active-high reset
//   start_in, cancel_in   request (sampled in IDLE only) / abort
//   mode_in [1:0]         00 unsigned, 01 signed, 10 FP mantissa, 11 as 00
//   n_in, d_in [WD-1:0]   dividend / divisor
//   busy_out              operation in flight
//   valid_out             one-cycle result strobe
//   q_out, r_out [WD-1:0] quotient / remainder (held until next result)
//   sticky_out            final remainder nonzero
//   divzero_out           divisor was zero
module relm_custom_div_seq
  import relm_div_pkg::*;
#(
  parameter int WD  = 32,
  parameter int BPC = 2
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start_in,
  input  logic          cancel_in,
  input  logic [1:0]    mode_in,
  input  logic [WD-1:0] n_in,
  input  logic [WD-1:0] d_in,
  output logic          busy_out,
  output logic          valid_out,
  output logic [WD-1:0] q_out,
  output logic [WD-1:0] r_out,
  output logic          sticky_out,
  output logic          divzero_out
);

  localparam int NUM_ITER = divIter(WD, BPC);
  localparam int CNT_BITS = divCntW(WD, BPC);

  divState_e             state_q, state_d;
  logic [CNT_BITS-1:0]   cnt_q, cnt_d;
  logic [WD:0]           rem_q, rem_d;
  logic [WD-1:0]         qd_q, qd_d;
  logic [WD-1:0]         dAbs_q, dAbs_d;
  logic [WD-1:0]         nRaw_q, nRaw_d;
  logic                  negQ_q, negQ_d;
  logic                  negR_q, negR_d;
  logic                  dz_q, dz_d;
  logic                  valid_q, valid_d;
  logic [WD-1:0]         qOut_q, qOut_d;
  logic [WD-1:0]         rOut_q, rOut_d;
  logic                  sticky_q, sticky_d;
  logic                  dzOut_q, dzOut_d;

  logic [WD:0]           remChain [BPC+1];
  logic [BPC-1:0]        qBits;

  logic                  isSigned, isFp;
  logic [WD-1:0]         nAbs, dAbsIn, qFix, remLow, rFix;

  // qd_q starts as the dividend and doubles as the quotient register:
  // dividend bits leave at the MSB end while quotient bits enter at the LSB.
  assign remChain[0] = rem_q;

  for (genvar i = 0; i < BPC; i++) begin : g_step
    relm_div_step #(.WD(WD)) u_step (
      .rem_i (remChain[i]),
      .d_i   (dAbs_q),
      .bit_i (qd_q[WD-1-i]),
      .rem_o (remChain[i+1]),
      .q_o   (qBits[BPC-1-i])
    );
  end

  // Next-state and datapath logic. FP mode preloads rem = n>>1 and feeds n[0]
  // as the first shifted-in bit, so the shift-then-subtract step sees n on its
  // first compare and zeros afterwards: q = floor(n * 2^(WD-1) / d).
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    rem_d    = rem_q;
    qd_d     = qd_q;
    dAbs_d   = dAbs_q;
    nRaw_d   = nRaw_q;
    negQ_d   = negQ_q;
    negR_d   = negR_q;
    dz_d     = dz_q;
    valid_d  = 1'b0;
    qOut_d   = qOut_q;
    rOut_d   = rOut_q;
    sticky_d = sticky_q;
    dzOut_d  = dzOut_q;

    isSigned = (mode_in == DIVM_S);
    isFp     = (mode_in == DIVM_FP);
    nAbs     = (isSigned && n_in[WD-1]) ? -n_in : n_in;
    dAbsIn   = (isSigned && d_in[WD-1]) ? -d_in : d_in;
    qFix     = negQ_q ? -qd_q : qd_q;
    remLow   = rem_q[WD-1:0];
    rFix     = negR_q ? -remLow : remLow;

    case (state_q)
      S_IDLE: begin
        if (start_in && !cancel_in) begin
          state_d = S_LOOP;
          cnt_d   = CNT_BITS'(NUM_ITER);
          dAbs_d  = dAbsIn;
          nRaw_d  = n_in;
          negQ_d  = isSigned & (n_in[WD-1] ^ d_in[WD-1]);
          negR_d  = isSigned & n_in[WD-1];
          dz_d    = (d_in == '0);
          if (isFp) begin
            rem_d = {2'b00, n_in[WD-1:1]};
            qd_d  = {n_in[0], {(WD-1){1'b0}}};
          end else begin
            rem_d = '0;
            qd_d  = nAbs;
          end
        end
      end
      S_LOOP: begin
        if (cancel_in) begin
          state_d = S_IDLE;
        end else begin
          rem_d = remChain[BPC];
          qd_d  = {qd_q[WD-BPC-1:0], qBits};
          cnt_d = cnt_q - CNT_BITS'(1);
          if (cnt_q == CNT_BITS'(1)) begin
            state_d = S_POST;
          end
        end
      end
      S_POST: begin
        state_d = S_IDLE;
        if (!cancel_in) begin
          valid_d = 1'b1;
          dzOut_d = dz_q;
          // A zero divisor bypasses the sign fix and reports the raw dividend.
          if (dz_q) begin
            qOut_d   = '1;
            rOut_d   = nRaw_q;
            sticky_d = |nRaw_q;
          end else begin
            qOut_d   = qFix;
            rOut_d   = rFix;
            sticky_d = |remLow;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      rem_q    <= '0;
      qd_q     <= '0;
      dAbs_q   <= '0;
      nRaw_q   <= '0;
      negQ_q   <= 1'b0;
      negR_q   <= 1'b0;
      dz_q     <= 1'b0;
      valid_q  <= 1'b0;
      qOut_q   <= '0;
      rOut_q   <= '0;
      sticky_q <= 1'b0;
      dzOut_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      rem_q    <= rem_d;
      qd_q     <= qd_d;
      dAbs_q   <= dAbs_d;
      nRaw_q   <= nRaw_d;
      negQ_q   <= negQ_d;
      negR_q   <= negR_d;
      dz_q     <= dz_d;
      valid_q  <= valid_d;
      qOut_q   <= qOut_d;
      rOut_q   <= rOut_d;
      sticky_q <= sticky_d;
      dzOut_q  <= dzOut_d;
    end
  end

  assign busy_out    = (state_q != S_IDLE);
  assign valid_out   = valid_q;
  assign q_out       = qOut_q;
  assign r_out       = rOut_q;
  assign sticky_out  = sticky_q;
  assign divzero_out = dzOut_q;

endmodule
